weight_rom_arbiter: RTL and testbench
=====================================

WEIGHT_ROM_ARBITER -- requirements
Module: weight_rom_arbiter

Interface
REQ-001 SHALL provide parameter WIDTH, default 16, ROM data width in bits.
REQ-002 SHALL provide parameter ADDRWIDTH, default 8, ROM address width in bits.
REQ-003 SHALL provide parameter LENWIDTH, default 8, burst length field width in bits.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on posedge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have ports reqN_valid, input, 1 bit, N=0,1: requester N presents a burst.
REQ-007 SHALL have ports reqN_ready, output, 1 bit: burst from requester N accepted this cycle if reqN_valid is high.
REQ-008 SHALL have ports reqN_base, input, ADDRWIDTH bits: first word address of the burst.
REQ-009 SHALL have ports reqN_len, input, LENWIDTH bits: number of words in the burst.
REQ-010 SHALL have ports outN_valid, output, 1 bit: outN_data carries a burst word for requester N.
REQ-011 SHALL have ports outN_data, output, WIDTH bits: word returned to requester N.
REQ-012 SHALL have ports doneN, output, 1 bit: one-cycle pulse marking the end of requester N's burst.
REQ-013 SHALL have port rom_en, output, 1 bit: read enable to the single-port ROM.
REQ-014 SHALL have port rom_addr, output, ADDRWIDTH bits: read address to the ROM.
REQ-015 SHALL have port rom_dout, input, WIDTH bits: ROM read data, registered, valid one cycle after rom_en.

Function
REQ-016 SHALL implement states IDLE, BURST and DRAIN.
REQ-017 In IDLE, SHALL assert reqN_ready combinationally only for the requester selected by arbitration, and only when that requester's valid is high; both ready outputs SHALL be low outside IDLE.
REQ-018 Arbitration SHALL be round-robin: a single valid request wins; if both are valid, the requester not granted last wins; the last-grant pointer SHALL update on every acceptance.
REQ-019 On acceptance (valid&&ready) with len>0, SHALL latch base, len and owner, then enter BURST.
REQ-020 In BURST, SHALL drive rom_en=1 and rom_addr=base+k for k=0..len-1 on consecutive cycles; the address SHALL wrap modulo 2^ADDRWIDTH.
REQ-021 After the cycle that issues the last address, SHALL enter DRAIN for exactly one cycle, then return to IDLE.
REQ-022 outN_valid SHALL be a registered copy of (rom_en && owner==N), so it is high exactly one cycle after each issue; outN_data SHALL equal rom_dout when outN_valid is high and 0 otherwise.
REQ-023 doneN SHALL pulse high in the same cycle as the last outN_valid of the burst.
REQ-024 Latency: accept at cycle 0 gives issues at cycles 1..len, data at cycles 2..len+1, done at cycle len+1, and IDLE (ready possible) at cycle len+2.
REQ-025 On acceptance with len==0, SHALL issue no ROM read, enter DRAIN, assert doneN in the DRAIN cycle with outN_valid low, and return to IDLE.
REQ-026 reqN_base and reqN_len changes after acceptance SHALL NOT affect the burst in progress.
REQ-027 rom_en SHALL be low in IDLE and DRAIN.
REQ-028 Requests arriving outside IDLE SHALL be held pending (ready low) and never dropped.
REQ-029 len = 2^LENWIDTH-1 SHALL be supported without counter overflow.

Reset
REQ-030 While rst_n is low, SHALL force state IDLE, rom_en=0, rom_addr=0, all outN_valid=0, outN_data=0, doneN=0, and last-grant pointer=1 so that requester 0 wins the first tie.
REQ-031 Reset asserted mid-burst SHALL abort the burst immediately, emit no further valid or done, and resume from IDLE after release.

Verification
REQ-032 Single burst: req0 base=0x10, len=3 accepted at cycle 0 -> rom_addr 0x10,0x11,0x12 at cycles 1-3; out0_valid at cycles 2-4 with matching ROM words; done0 at cycle 4; ready possible at cycle 5.
REQ-033 Contention: req0 and req1 both valid from reset, each len=2 -> req0 served first, req1 accepted at the next IDLE, done0 precedes done1, and out1_valid is never high during req0's burst.
REQ-034 Wrap: base=0xFE, len=4, ADDRWIDTH=8 -> rom_addr sequence 0xFE, 0xFF, 0x00, 0x01.
REQ-035 Zero length: req1 len=0 -> no rom_en, done1 pulses one cycle after acceptance, out1_valid stays low.
REQ-036 Reset mid-burst: rst_n low at cycle 2 of a len=8 burst -> rom_en, out0_valid and done0 go to 0 immediately; after release, a new req1 is accepted normally.
REQ-037 Fairness: both requesters continuously valid for 6 bursts -> grants alternate 0,1,0,1,0,1.

Source files
------------

// File: rtl/weight_rom_arbiter.sv
// Two-requester round-robin arbiter sharing one single-port weight ROM.
// A granted burst streams len consecutive words back to its owner, then a one-cycle drain.
module weight_rom_arbiter #(
  parameter int WIDTH     = 16,
  parameter int ADDRWIDTH = 8,
  parameter int LENWIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [ADDRWIDTH-1:0] req0_base,
  input  logic [LENWIDTH-1:0]  req0_len,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [ADDRWIDTH-1:0] req1_base,
  input  logic [LENWIDTH-1:0]  req1_len,
  output logic                 out0_valid,
  output logic [WIDTH-1:0]     out0_data,
  output logic                 out1_valid,
  output logic [WIDTH-1:0]     out1_data,
  output logic                 done0,
  output logic                 done1,
  output logic                 rom_en,
  output logic [ADDRWIDTH-1:0] rom_addr,
  input  logic [WIDTH-1:0]     rom_dout
);

  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

  state_t                state_q, state_d;
  logic [ADDRWIDTH-1:0]  addr_q, addr_d;
  logic [LENWIDTH-1:0]   left_q, left_d;
  logic                  owner_q, owner_d;
  logic                  last_q, last_d;
  logic                  sel;
  logic                  accept;
  logic [1:0]            vld_p1;

  // Round-robin pick: a lone requester wins, a tie goes to the one not granted last.
  always_comb begin
    sel = 1'b0;
    if (req0_valid && req1_valid) sel = ~last_q;
    else if (req1_valid)          sel = 1'b1;
  end

  assign req0_ready = (state_q == IDLE) && req0_valid && !sel;
  assign req1_ready = (state_q == IDLE) && req1_valid &&  sel;
  assign accept     = req0_ready || req1_ready;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    left_d  = left_q;
    owner_d = owner_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          owner_d = sel;
          last_d  = sel;
          addr_d  = sel ? req1_base : req0_base;
          left_d  = sel ? req1_len  : req0_len;
          state_d = ((sel ? req1_len : req0_len) == '0) ? DRAIN : BURST;
        end
      end
      BURST: begin
        // left_q counts issues still outstanding including this one, so max len never overflows
        addr_d = addr_q + ADDRWIDTH'(1);
        left_d = left_q - LENWIDTH'(1);
        if (left_q == LENWIDTH'(1)) state_d = DRAIN;
      end
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      left_q  <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      left_q  <= left_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  assign rom_en   = (state_q == BURST);
  assign rom_addr = addr_q;

  // ---- stage p1: ROM word returns one cycle after issue ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p1 <= 2'b00;
    else        vld_p1 <= {rom_en && owner_q, rom_en && !owner_q};
  end

  assign out0_valid = vld_p1[0];
  assign out1_valid = vld_p1[1];
  assign out0_data  = vld_p1[0] ? rom_dout : '0;
  assign out1_data  = vld_p1[1] ? rom_dout : '0;

  // The drain cycle coincides with the last returned word, or stands alone for len==0.
  assign done0 = (state_q == DRAIN) && !owner_q;
  assign done1 = (state_q == DRAIN) &&  owner_q;

endmodule

// File: tb/tb_weight_rom_arbiter.sv
// Bench for weight_rom_arbiter: per-cycle expectations built from a transaction-level
// schedule of the two burst queues, plus a behavioural registered ROM.
module tb_weight_rom_arbiter;

  localparam int MAXC = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [7:0]  req0_base, req1_base;
  logic [7:0]  req0_len, req1_len;
  logic        out0_valid, out1_valid;
  logic [15:0] out0_data, out1_data;
  logic        done0, done1;
  logic        rom_en;
  logic [7:0]  rom_addr;
  logic [15:0] rom_dout;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct packed {
    logic [7:0] base;
    logic [7:0] len;
  } burst_t;

  burst_t q0[$];
  burst_t q1[$];
  logic   m_last;

  logic        e_rdy0[MAXC], e_rdy1[MAXC], e_en[MAXC];
  logic        e_v0[MAXC], e_v1[MAXC], e_dn0[MAXC], e_dn1[MAXC];
  logic [7:0]  e_addr[MAXC];
  logic [15:0] e_d0[MAXC], e_d1[MAXC];

  weight_rom_arbiter #(.WIDTH(16), .ADDRWIDTH(8), .LENWIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_base(req0_base), .req0_len(req0_len),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_base(req1_base), .req1_len(req1_len),
    .out0_valid(out0_valid), .out0_data(out0_data),
    .out1_valid(out1_valid), .out1_data(out1_data),
    .done0(done0), .done1(done1),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_dout(rom_dout)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rom_word(input logic [7:0] a);
    return {a ^ 8'h5A, a + 8'h33};
  endfunction

  always_ff @(posedge clk) if (rom_en) rom_dout <= rom_word(rom_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_all(input int i);
    chk("ready0", 32'(req0_ready), 32'(e_rdy0[i]));
    chk("ready1", 32'(req1_ready), 32'(e_rdy1[i]));
    chk("rom_en", 32'(rom_en), 32'(e_en[i]));
    if (e_en[i]) chk("rom_addr", 32'(rom_addr), 32'(e_addr[i]));
    chk("out0_valid", 32'(out0_valid), 32'(e_v0[i]));
    chk("out0_data", 32'(out0_data), 32'(e_d0[i]));
    chk("out1_valid", 32'(out1_valid), 32'(e_v1[i]));
    chk("out1_data", 32'(out1_data), 32'(e_d1[i]));
    chk("done0", 32'(done0), 32'(e_dn0[i]));
    chk("done1", 32'(done1), 32'(e_dn1[i]));
  endtask

  // Plans the whole exchange as a sequence of grants, then replays it cycle by cycle.
  task automatic run_scn();
    int p0, p1, t, tend;
    logic win;
    burst_t b;
    logic [7:0] a;
    for (int i = 0; i < MAXC; i++) begin
      e_rdy0[i] = 0; e_rdy1[i] = 0; e_en[i] = 0; e_addr[i] = 0;
      e_v0[i] = 0; e_v1[i] = 0; e_d0[i] = 0; e_d1[i] = 0; e_dn0[i] = 0; e_dn1[i] = 0;
    end
    p0 = 0; p1 = 0; t = 0;
    while (p0 < q0.size() || p1 < q1.size()) begin
      if (p0 < q0.size() && p1 < q1.size()) win = ~m_last;
      else win = (p0 < q0.size()) ? 1'b0 : 1'b1;
      b = win ? q1[p1] : q0[p0];
      if (win) begin e_rdy1[t] = 1; p1++; end
      else     begin e_rdy0[t] = 1; p0++; end
      for (int k = 0; k < int'(b.len); k++) begin
        a = b.base + 8'(k);
        e_en[t+1+k] = 1;
        e_addr[t+1+k] = a;
        if (win) begin e_v1[t+2+k] = 1; e_d1[t+2+k] = rom_word(a); end
        else     begin e_v0[t+2+k] = 1; e_d0[t+2+k] = rom_word(a); end
      end
      if (win) e_dn1[t+int'(b.len)+1] = 1;
      else     e_dn0[t+int'(b.len)+1] = 1;
      t = t + int'(b.len) + 2;
      m_last = win;
    end
    tend = t;
    p0 = 0; p1 = 0;
    for (int i = 0; i < tend; i++) begin
      cyc = i;
      req0_valid = (p0 < q0.size());
      req0_base  = (p0 < q0.size()) ? q0[p0].base : 8'($urandom);
      req0_len   = (p0 < q0.size()) ? q0[p0].len  : 8'($urandom);
      req1_valid = (p1 < q1.size());
      req1_base  = (p1 < q1.size()) ? q1[p1].base : 8'($urandom);
      req1_len   = (p1 < q1.size()) ? q1[p1].len  : 8'($urandom);
      @(negedge clk);
      chk_all(i);
      if (e_rdy0[i]) p0++;
      if (e_rdy1[i]) p1++;
      @(posedge clk); #1;
    end
    req0_valid = 0;
    req1_valid = 0;
  endtask

  function automatic burst_t mk(input logic [7:0] base, input logic [7:0] len);
    burst_t b;
    b.base = base;
    b.len = len;
    return b;
  endfunction

  initial begin
    rst_n = 0;
    req0_valid = 0; req1_valid = 0;
    req0_base = 0; req1_base = 0; req0_len = 0; req1_len = 0;
    m_last = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rom_en", 32'(rom_en), 0);
    chk("rst_rom_addr", 32'(rom_addr), 0);
    chk("rst_out0_valid", 32'(out0_valid), 0);
    chk("rst_out1_valid", 32'(out1_valid), 0);
    chk("rst_out0_data", 32'(out0_data), 0);
    chk("rst_out1_data", 32'(out1_data), 0);
    chk("rst_done0", 32'(done0), 0);
    chk("rst_done1", 32'(done1), 0);
    @(posedge clk); #1;
    rst_n = 1;

    // contention straight out of reset: req0 wins the first tie
    q0 = '{}; q1 = '{};
    q0.push_back(mk(8'h20, 8'd2)); q1.push_back(mk(8'h80, 8'd2));
    run_scn();

    // single burst
    q0 = '{}; q1 = '{};
    q0.push_back(mk(8'h10, 8'd3));
    run_scn();

    // address wrap
    q0 = '{}; q1 = '{};
    q0.push_back(mk(8'hFE, 8'd4));
    run_scn();

    // zero length on req1
    q0 = '{}; q1 = '{};
    q1.push_back(mk(8'h33, 8'd0));
    run_scn();

    // fairness: six bursts with both continuously valid
    q0 = '{}; q1 = '{};
    for (int i = 0; i < 3; i++) begin
      q0.push_back(mk(8'(i * 16), 8'd2));
      q1.push_back(mk(8'(8'hA0 + i * 16), 8'd1));
    end
    run_scn();

    // maximum length burst
    q0 = '{}; q1 = '{};
    q1.push_back(mk(8'hC7, 8'd255));
    run_scn();

    // reset in the middle of a len=8 burst
    cyc = 0;
    req0_valid = 1; req0_base = 8'h40; req0_len = 8'd8; req1_valid = 0;
    @(negedge clk);
    chk("mid_ready0", 32'(req0_ready), 1);
    @(posedge clk); #1;
    req0_valid = 0; req0_base = 8'h99; req0_len = 8'd1;
    @(negedge clk);
    chk("mid_addr0", 32'(rom_addr), 32'h40);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_en", 32'(rom_en), 1);
    chk("mid_addr1", 32'(rom_addr), 32'h41);
    chk("mid_data", 32'(out0_data), 32'(rom_word(8'h40)));
    #1 rst_n = 0;
    #1;
    chk("abort_rom_en", 32'(rom_en), 0);
    chk("abort_rom_addr", 32'(rom_addr), 0);
    chk("abort_out0_valid", 32'(out0_valid), 0);
    chk("abort_out0_data", 32'(out0_data), 0);
    chk("abort_done0", 32'(done0), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("held_rom_en", 32'(rom_en), 0);
    chk("held_out0_valid", 32'(out0_valid), 0);
    @(posedge clk); #1;
    rst_n = 1;
    m_last = 1'b1;
    q0 = '{}; q1 = '{};
    q1.push_back(mk(8'h55, 8'd3));
    run_scn();

    // randomized traffic
    for (int s = 0; s < 25; s++) begin
      int n0, n1;
      q0 = '{}; q1 = '{};
      n0 = $urandom_range(0, 3);
      n1 = $urandom_range(0, 3);
      for (int i = 0; i < n0; i++)
        q0.push_back(mk(8'($urandom), ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 7))));
      for (int i = 0; i < n1; i++)
        q1.push_back(mk(8'($urandom), ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 7))));
      run_scn();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
